// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and clog2 helper
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK_WAIT
  } rx_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO; extra pointer MSB separates full from empty
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo_param.sv
// rtl/uart_rx_fifo_param.sv - UART receiver with 3-sample majority voting, error flags and output FIFO
// Line-break detection is built only when UART_RX_BREAK_EN is defined.
module uart_rx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 busy,
  output logic                 break_det
);

  localparam int              CW        = clog2(CLKS_PER_BIT);
  localparam int              HALF      = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_S0    = CW'(HALF - 1);
  localparam logic [CW-1:0]   CNT_S1    = CW'(HALF);
  localparam logic [CW-1:0]   CNT_DEC   = CW'(HALF + 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic            PAR_ODD   = (PARITY_MODE == PARITY_ODD);
  localparam int              FW        = DATA_BITS + 2;

  logic                 rx_meta, rx_s, rx_prev;
  rx_state_t            state, state_next;
  logic [CW-1:0]        bit_cnt;
  logic [3:0]           idx;
  logic                 s0, s1, maj, at_dec, at_end;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q, ferr_q, frame_ferr, frame_done, is_break;
  logic                 push_q;
  logic [FW-1:0]        push_word, head_word;
  logic                 fifo_full, fifo_empty;

  assign maj        = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign at_dec     = (bit_cnt == CNT_DEC);
  assign at_end     = (bit_cnt == CNT_LAST);
  assign frame_ferr = ferr_q | ~maj;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
      state   <= RX_IDLE;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
      state   <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    is_break   = 1'b0;
    case (state)
      RX_IDLE:   if (rx_prev && !rx_s) state_next = RX_START;
      RX_START:  if (at_dec && maj) state_next = RX_IDLE;
                 else if (at_end) state_next = RX_DATA;
      RX_DATA:   if (at_end && idx == DATA_LAST)
                   state_next = (PARITY_MODE == PARITY_NONE) ? RX_STOP : RX_PARITY;
      RX_PARITY: if (at_end) state_next = RX_STOP;
      RX_STOP: begin
        // Leave at the last stop decision rather than bit end to absorb baud mismatch.
        if (at_dec && idx == STOP_LAST) begin
          frame_done = 1'b1;
`ifdef UART_RX_BREAK_EN
          is_break = frame_ferr && (shreg == '0) &&
                     ((PARITY_MODE == PARITY_NONE) || (perr_q == PAR_ODD));
`endif
          state_next = is_break ? RX_BREAK_WAIT : RX_IDLE;
        end
      end
      RX_BREAK_WAIT: if (rx_s) state_next = RX_IDLE;
      default:   state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      idx       <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      shreg     <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      push_q <= frame_done && !is_break;
      if (frame_done) push_word <= {frame_ferr, perr_q, shreg};
      if (state == RX_IDLE || state == RX_BREAK_WAIT) begin
        bit_cnt <= '0;
        idx     <= '0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
      end else begin
        bit_cnt <= at_end ? '0 : bit_cnt + CNT_ONE;
        if (bit_cnt == CNT_S0) s0 <= rx_s;
        if (bit_cnt == CNT_S1) s1 <= rx_s;
        if (at_dec) begin
          case (state)
            RX_DATA:   shreg  <= {maj, shreg[DATA_BITS-1:1]};
            RX_PARITY: perr_q <= (maj != ((^shreg) ^ PAR_ODD));
            RX_STOP:   if (!maj) ferr_q <= 1'b1;
            default:   ;
          endcase
        end
        if (at_end && (state == RX_DATA || state == RX_STOP))
          idx <= (state == RX_DATA && idx == DATA_LAST) ? 4'd0 : idx + 4'd1;
      end
    end
  end

  uart_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_word),
    .pop       (m_ready),
    .pop_data  (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_valid                  = !fifo_empty;
  assign {m_ferr, m_perr, m_data} = head_word;
  assign overrun                  = push_q && fifo_full && !(m_ready && m_valid);
  assign busy                     = (state != RX_IDLE && state != RX_BREAK_WAIT) || push_q;

`ifdef UART_RX_BREAK_EN
  logic break_q;
  always_ff @(posedge clk) begin
    if (rst) break_q <= 1'b0;
    else     break_q <= is_break;
  end
  assign break_det = break_q;
`else
  assign break_det = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// tb/tb_uart_rx_fifo_param.sv - scoreboard bench for uart_rx_fifo_param (8E1, depth 4)
// Expectations follow UART_RX_BREAK_EN when it is defined for the build.
module tb_uart_rx_fifo_param;

  localparam int C     = 16;
  localparam int DB    = 8;
  localparam int PAR   = 1;
  localparam int SB    = 1;
  localparam int DEPTH = 4;
  localparam int NBITS = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
  // 2 sync flops + edge register, then the last stop decision at C/2+1, then 2 clk to valid.
  localparam int LAT   = 3 + (NBITS - 1) * C + (C / 2 + 1) + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          m_ready = 1'b0;
  logic [DB-1:0] m_data;
  logic          m_perr, m_ferr, m_valid, overrun, busy, break_det;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int frame_t0 = 0;
  int rise_cyc = -1;
  int exp_overruns = 0;
  int seen_overruns = 0;
  int exp_breaks = 0;
  int seen_breaks = 0;
  logic rand_ready = 1'b0;
  logic prev_valid = 1'b0;
  logic hold_v = 1'b0;
  logic [DB+1:0] hold_word = '0;
  logic [DB+1:0] exp_q[$];

  uart_rx_fifo_param #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (DB),
    .PARITY_MODE  (PAR),
    .STOP_BITS    (SB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .m_data    (m_data),
    .m_perr    (m_perr),
    .m_ferr    (m_ferr),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .overrun   (overrun),
    .busy      (busy),
    .break_det (break_det)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, actual running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx = v;
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // flip_idx: frame bit index (0 = start) whose centre sample is inverted for one clk; -1 = none.
  task automatic send_frame(input logic [DB-1:0] d, input logic bad_par,
                            input logic stop_low, input int flip_idx);
    logic bits[$];
    logic pbit;
    logic brk;
    pbit = (^d) ^ (PAR == 2) ^ bad_par;
    bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) bits.push_back(d[i]);
    if (PAR != 0) bits.push_back(pbit);
    for (int i = 0; i < SB; i++) bits.push_back(~stop_low);
`ifdef UART_RX_BREAK_EN
    brk = (d == '0) && stop_low && ((PAR == 0) || (pbit == 1'b0));
`else
    brk = 1'b0;
`endif
    if (brk) exp_breaks++;
    else if (!m_ready && exp_q.size() >= DEPTH) exp_overruns++;
    else exp_q.push_back({stop_low, (PAR != 0) && bad_par, d});
    for (int i = 0; i < NBITS; i++)
      for (int j = 0; j < C; j++) begin
        @(posedge clk); #1;
        if (i == 0 && j == 0) frame_t0 = cyc;
        rx = (i == flip_idx && j == C / 2 + 1) ? ~bits[i] : bits[i];
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      end
    drive(1'b1, C);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_v     = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (m_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = m_valid;
      if (hold_v && m_valid) check("hold_stable", {m_ferr, m_perr, m_data}, hold_word);
      hold_v    = m_valid && !m_ready;
      hold_word = {m_ferr, m_perr, m_data};
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: actual %0h required no word", {m_ferr, m_perr, m_data});
        end else begin
          check("word", {m_ferr, m_perr, m_data}, exp_q.pop_front());
        end
      end
      if (overrun) seen_overruns++;
      if (break_det) seen_breaks++;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_perr", m_perr, 0);
    check("rst_m_ferr", m_ferr, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_break_det", break_det, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 4);

    send_frame(8'hA5, 1'b0, 1'b0, -1);
    check("valid_latency", rise_cyc - frame_t0, LAT);
    check("a5_valid_held", m_valid, 1);
    m_ready = 1'b1;
    drain();

    send_frame(8'h03, 1'b1, 1'b0, -1);
    drain();

    for (int g = 0; g < 2; g++) begin
      drive(1'b0, (g == 0) ? 1 : 3);
      drive(1'b1, 3);
      @(negedge clk);
      check("glitch_busy_rise", busy, 1);
      drive(1'b1, 2 * C);
      @(negedge clk);
      check("glitch_busy_idle", busy, 0);
      check("glitch_no_push", m_valid, 0);
    end

    m_ready = 1'b0;
    for (int f = 0; f < DEPTH + 1; f++) send_frame(8'($urandom), 1'b0, 1'b0, -1);
    check("overrun_pulses", seen_overruns, 1);
    check("full_valid", m_valid, 1);
    m_ready = 1'b1;
    drain();
    drive(1'b1, 4);
    @(negedge clk);
    check("drained_exactly_depth", m_valid, 0);

    send_frame(8'h55, 1'b0, 1'b1, -1);
    send_frame(8'h55, 1'b0, 1'b0, 3);
    drain();

    rand_ready = 1'b1;
    for (int f = 0; f < 16; f++)
      send_frame(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DB)) : -1);
    rand_ready = 1'b0;
    m_ready = 1'b1;
    drain();

`ifdef UART_RX_BREAK_EN
    exp_breaks++;
`else
    exp_q.push_back({1'b1, 1'b0, 8'h00});
`endif
    drive(1'b0, 2 * NBITS * C);
    drive(1'b1, 2 * C);
    drain();
    check("break_pulses", seen_breaks, exp_breaks);

    drive(1'b0, C);
    drive(1'b1, C);
    drive(1'b0, C);
    @(negedge clk);
    check("busy_mid_frame", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 2 * C);
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_empty", m_valid, 0);
    send_frame(8'($urandom), 1'b0, 1'b0, -1);
    drain();

    drive(1'b1, 8);
    check("overruns_total", seen_overruns, exp_overruns);
    check("breaks_total", seen_breaks, exp_breaks);
    @(negedge clk);
    check("final_empty", m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
